// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge: transfer qualification, peripheral decode,
// pipeline registers and the two-cycle ERROR response. Optional macro: AHB_SLV_HOLD_EN.
module ahb_slave_if #(
    parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
    parameter logic [31:0] WIN_SIZE  = 32'h0400_0000
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        valid,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hwdata1,
    output logic [31:0] Hwdata2,
    output logic        Hwritereg,
    output logic [2:0]  tempselx,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic        Herr_hold,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        StOk   = 2'b00,
        StErr1 = 2'b01,
        StErr2 = 2'b10
    } err_state_e;

    err_state_e state_q, state_d;
    logic [7:0] err_count_q;
    logic       err_inc;
    logic       act;
    logic       unmapped;
    logic       pipe_load;
    logic       unused_htrans0;

    // Offset compare wraps naturally, so an address below a base never lands in its window.
    logic [31:0] off0, off1, off2;
    assign off0 = Haddr - SLV0_BASE;
    assign off1 = Haddr - SLV1_BASE;
    assign off2 = Haddr - SLV2_BASE;

    always_comb begin
        tempselx = 3'b000;
        if (off0 < WIN_SIZE) begin
            tempselx = 3'b001;
        end else if (off1 < WIN_SIZE) begin
            tempselx = 3'b010;
        end else if (off2 < WIN_SIZE) begin
            tempselx = 3'b100;
        end
    end

    assign unused_htrans0 = Htrans[0];
    assign act            = Hreadyin & Htrans[1];
    assign unmapped       = (tempselx == 3'b000);
    assign valid          = act & ~unmapped & (state_q != StErr1);
    assign Hrdata         = Prdata;
    assign err_count      = err_count_q;

`ifdef AHB_SLV_HOLD_EN
    assign pipe_load = Hreadyin;
`else
    assign pipe_load = 1'b1;
`endif

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Haddr1    <= 32'h0;
            Haddr2    <= 32'h0;
            Hwdata1   <= 32'h0;
            Hwdata2   <= 32'h0;
            Hwritereg <= 1'b0;
        end else if (pipe_load) begin
            Haddr1    <= Haddr;
            Haddr2    <= Haddr1;
            Hwdata1   <= Hwdata;
            Hwdata2   <= Hwdata1;
            Hwritereg <= Hwrite;
        end
    end

    always_comb begin
        state_d   = StOk;
        err_inc   = 1'b0;
        Hresp     = 2'b00;
        Herr_hold = 1'b0;
        case (state_q)
            StOk: begin
                if (act && unmapped) begin
                    state_d = StErr1;
                    err_inc = 1'b1;
                end
            end
            StErr1: begin
                Hresp     = 2'b01;
                Herr_hold = 1'b1;
                state_d   = StErr2;
            end
            StErr2: begin
                Hresp = 2'b01;
                if (act && unmapped) begin
                    state_d = StErr1;
                    err_inc = 1'b1;
                end
            end
            default: state_d = StOk;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= StOk;
            err_count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (err_inc && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'h01;
            end
        end
    end

endmodule
